fetch_pc_unit: RTL and testbench

Parametrised program-counter and fetch-request generator at the front of the pipeline. It holds the architectural fetch PC, chooses between sequential advance and prioritised redirects from several pipeline stages, and presents fetch requests to instruction memory over a valid/ready handshake. It tags each request with a redirect epoch so downstream stages can discard stale instructions, and it stops fetching when the sequential path reaches a halt address.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/redir_arbiter.sv | 36 +++
 rtl/fetch_pc_unit.sv | 98 +++++++++
 tb/tb_fetch_pc_unit.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default parameters for the fetch program-counter unit.
// The state encoding is shared with any stage that observes fetch status.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    localparam int DEF_PC_SIZE    = 32;
    localparam int DEF_INST_BYTES = 4;
    localparam int DEF_N_REDIR    = 3;
    localparam int DEF_EPOCH_W    = 2;

endpackage

// File: rtl/redir_arbiter.sv
// Fixed-priority redirect select; channel 0 wins.
// Purely combinational; also aligns the target and flags dropped low bits.
module redir_arbiter
    import fetch_pkg::*;
#(
    parameter int PC_SIZE    = DEF_PC_SIZE,
    parameter int INST_BYTES = DEF_INST_BYTES,
    parameter int N_REDIR    = DEF_N_REDIR
) (
    input  logic [N_REDIR-1:0]         redir_valid,
    input  logic [N_REDIR*PC_SIZE-1:0] redir_target,
    output logic                       any_valid,
    output logic [PC_SIZE-1:0]         target,
    output logic                       misalign
);

    logic [PC_SIZE-1:0] raw_target;
    logic [PC_SIZE-1:0] low_mask;

    // Walk from lowest to highest priority so channel 0 is written last.
    always_comb begin
        any_valid  = 1'b0;
        raw_target = '0;
        for (int i = N_REDIR - 1; i >= 0; i--) begin
            if (redir_valid[i]) begin
                any_valid  = 1'b1;
                raw_target = redir_target[i*PC_SIZE +: PC_SIZE];
            end
        end
    end

    assign low_mask = PC_SIZE'(INST_BYTES - 1);
    assign misalign = |(raw_target & low_mask);
    assign target   = raw_target & ~low_mask;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC holder and fetch-request generator with prioritised redirects,
// epoch tagging of requests and a sequential halt address.
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter int                  PC_SIZE    = DEF_PC_SIZE,
    parameter int                  INST_BYTES = DEF_INST_BYTES,
    parameter int                  N_REDIR    = DEF_N_REDIR,
    parameter int                  EPOCH_W    = DEF_EPOCH_W,
    parameter logic [PC_SIZE-1:0]  HALT_PC    = {PC_SIZE{1'b1}}
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [PC_SIZE-1:0]         entry,
    input  logic [N_REDIR-1:0]         redir_valid,
    input  logic [N_REDIR*PC_SIZE-1:0] redir_target,
    output logic                       req_valid,
    input  logic                       req_ready,
    output logic [PC_SIZE-1:0]         req_pc,
    output logic [EPOCH_W-1:0]         req_epoch,
    output logic                       redir_taken,
    output logic                       misalign,
    output logic                       halted
);

    fetch_state_e       state;
    logic [PC_SIZE-1:0] pc;
    logic [EPOCH_W-1:0] epoch;
    logic [PC_SIZE-1:0] seq_next;

    logic               any_valid;
    logic [PC_SIZE-1:0] win_target;
    logic               win_misalign;

    redir_arbiter #(
        .PC_SIZE    (PC_SIZE),
        .INST_BYTES (INST_BYTES),
        .N_REDIR    (N_REDIR)
    ) u_arb (
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .any_valid    (any_valid),
        .target       (win_target),
        .misalign     (win_misalign)
    );

    assign seq_next  = pc + PC_SIZE'(INST_BYTES);
    assign req_pc    = pc;
    assign req_epoch = epoch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= BOOT;
            pc          <= '0;
            epoch       <= '0;
            req_valid   <= 1'b0;
            redir_taken <= 1'b0;
            misalign    <= 1'b0;
            halted      <= 1'b0;
        end else begin
            redir_taken <= 1'b0;
            misalign    <= 1'b0;
            case (state)
                BOOT: begin
                    pc        <= entry;
                    state     <= FETCH;
                    req_valid <= 1'b1;
                end
                FETCH, HALTED: begin
                    // A redirect also retracts an unaccepted request.
                    if (any_valid) begin
                        pc          <= win_target;
                        epoch       <= epoch + EPOCH_W'(1);
                        redir_taken <= 1'b1;
                        misalign    <= win_misalign;
                        state       <= FETCH;
                        req_valid   <= 1'b1;
                        halted      <= 1'b0;
                    end else if (state == FETCH && req_ready) begin
                        if (seq_next == HALT_PC) begin
                            state     <= HALTED;
                            req_valid <= 1'b0;
                            halted    <= 1'b1;
                        end else begin
                            pc <= seq_next;
                        end
                    end
                end
                default: begin
                    state     <= BOOT;
                    req_valid <= 1'b0;
                    halted    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed-vector bench for fetch_pc_unit; two instances differ only in
// HALT_PC so both the halt stop and the address wrap can be exercised.
module tb_fetch_pc_unit;

    logic        clk;
    logic        reset;
    logic [31:0] entry;
    logic [2:0]  redir_valid;
    logic [95:0] redir_target;
    logic        req_ready;

    logic        req_valid, redir_taken, misalign, halted;
    logic [31:0] req_pc;
    logic [1:0]  req_epoch;

    logic        b_req_valid, b_redir_taken, b_misalign, b_halted;
    logic [31:0] b_req_pc;
    logic [1:0]  b_req_epoch;

    int nvec = 0;
    int nerr = 0;

    fetch_pc_unit #(.HALT_PC(32'hFFFF_FFFC)) dut (
        .clk          (clk),
        .reset        (reset),
        .entry        (entry),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_pc       (req_pc),
        .req_epoch    (req_epoch),
        .redir_taken  (redir_taken),
        .misalign     (misalign),
        .halted       (halted)
    );

    fetch_pc_unit #(.HALT_PC(32'h0000_0010)) dut2 (
        .clk          (clk),
        .reset        (reset),
        .entry        (entry),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .req_valid    (b_req_valid),
        .req_ready    (req_ready),
        .req_pc       (b_req_pc),
        .req_epoch    (b_req_epoch),
        .redir_taken  (b_redir_taken),
        .misalign     (b_misalign),
        .halted       (b_halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {req_valid, req_pc, req_epoch, redir_taken, misalign, halted}
    function automatic logic [37:0] obs_a();
        return {req_valid, req_pc, req_epoch, redir_taken, misalign, halted};
    endfunction

    function automatic logic [37:0] obs_b();
        return {b_req_valid, b_req_pc, b_req_epoch,
                b_redir_taken, b_misalign, b_halted};
    endfunction

    function automatic logic [37:0] exp_v(input logic v, input logic [31:0] pc,
                                          input logic [1:0] ep, input logic rt,
                                          input logic mis, input logic h);
        return {v, pc, ep, rt, mis, h};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [37:0] e;
        reset = 1'b1;
        entry = 32'h1000;
        req_ready = 1'b1;
        redir_valid = '0;
        redir_target = '0;
        step();
        e = exp_v(0, 32'h0, 2'd0, 0, 0, 0);
        nvec++;
        if (obs_a() !== e) begin
            nerr++;
            $display("FAIL reset: got %h want %h", obs_a(), e);
        end
        reset = 1'b0;
        step();
        e = exp_v(1, 32'h1000, 2'd0, 0, 0, 0);
        nvec++;
        if (obs_a() !== e) begin
            nerr++;
            $display("FAIL boot: got %h want %h", obs_a(), e);
        end
    endtask

    task automatic test_sequential();
        logic [37:0] e;
        for (int i = 1; i <= 2; i++) begin
            step();
            e = exp_v(1, 32'h1000 + 32'(4 * i), 2'd0, 0, 0, 0);
            nvec++;
            if (obs_a() !== e) begin
                nerr++;
                $display("FAIL seq%0d: got %h want %h", i, obs_a(), e);
            end
        end
    endtask

    task automatic test_stall();
        logic [37:0] e;
        req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            e = exp_v(1, 32'h1008, 2'd0, 0, 0, 0);
            nvec++;
            if (obs_a() !== e) begin
                nerr++;
                $display("FAIL stall%0d: got %h want %h", i, obs_a(), e);
            end
        end
        req_ready = 1'b1;
        step();
        e = exp_v(1, 32'h100C, 2'd0, 0, 0, 0);
        nvec++;
        if (obs_a() !== e) begin
            nerr++;
            $display("FAIL resume: got %h want %h", obs_a(), e);
        end
    endtask

    task automatic test_priority();
        logic [37:0] e;
        redir_target = {32'h3000, 32'h2002, 32'hDEAD_0000};
        redir_valid = 3'b110;
        step();
        e = exp_v(1, 32'h2000, 2'd1, 1, 1, 0);
        nvec++;
        if (obs_a() !== e) begin
            nerr++;
            $display("FAIL prio: got %h want %h", obs_a(), e);
        end
        redir_valid = 3'b000;
        step();
        e = exp_v(1, 32'h2004, 2'd1, 0, 0, 0);
        nvec++;
        if (obs_a() !== e) begin
            nerr++;
            $display("FAIL prio_pulse: got %h want %h", obs_a(), e);
        end
    endtask

    task automatic test_epoch_wrap();
        logic [37:0] e;
        logic [31:0] t;
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            t = 32'h4000 + 32'(i * 256) + ((i == 3) ? 32'h3 : 32'h0);
            redir_target = {32'h9999_0000, 32'h0, t};
            redir_valid = (i == 1) ? 3'b101 : 3'b001;
            req_ready = (i == 2) ? 1'b0 : 1'b1;
            step();
            e = exp_v(1, 32'h4000 + 32'(i * 256), 2'(i + 1), 1,
                      (i == 3), 0);
            nvec++;
            if (obs_a() !== e) begin
                nerr++;
                $display("FAIL epoch%0d: got %h want %h", i, obs_a(), e);
            end
        end
        redir_valid = 3'b000;
        req_ready = 1'b0;
        step();
        e = exp_v(1, 32'h4300, 2'd0, 0, 0, 0);
        nvec++;
        if (obs_a() !== e) begin
            nerr++;
            $display("FAIL epoch_hold: got %h want %h", obs_a(), e);
        end
        req_ready = 1'b1;
    endtask

    task automatic test_halt();
        logic [37:0] e;
        reset = 1'b1;
        entry = 32'hFFFF_FFF8;
        step();
        reset = 1'b0;
        step();
        e = exp_v(1, 32'hFFFF_FFF8, 2'd0, 0, 0, 0);
        nvec++;
        if (obs_a() !== e) begin
            nerr++;
            $display("FAIL halt_boot: got %h want %h", obs_a(), e);
        end
        step();
        e = exp_v(1, 32'hFFFF_FFFC, 2'd0, 0, 0, 0);
        nvec++;
        if (obs_b() !== e) begin
            nerr++;
            $display("FAIL b_advance: got %h want %h", obs_b(), e);
        end
        for (int i = 0; i < 3; i++) begin
            e = exp_v(0, 32'hFFFF_FFF8, 2'd0, 0, 0, 1);
            nvec++;
            if (obs_a() !== e) begin
                nerr++;
                $display("FAIL halted%0d: got %h want %h", i, obs_a(), e);
            end
            step();
        end
        redir_target = {32'h0, 32'h0, 32'h0};
        redir_valid = 3'b001;
        #0;
        step();
        e = exp_v(1, 32'h0, 2'd1, 1, 0, 0);
        nvec++;
        if (obs_a() !== e) begin
            nerr++;
            $display("FAIL unhalt: got %h want %h", obs_a(), e);
        end
        redir_target = {32'h0, 32'h0, 32'hFFFF_FFFC};
        step();
        e = exp_v(1, 32'hFFFF_FFFC, 2'd2, 1, 0, 0);
        nvec++;
        if (obs_a() !== e) begin
            nerr++;
            $display("FAIL redir_haltpc: got %h want %h", obs_a(), e);
        end
        redir_valid = 3'b000;
        step();
        e = exp_v(1, 32'h0, 2'd2, 0, 0, 0);
        nvec++;
        if (obs_a() !== e) begin
            nerr++;
            $display("FAIL wrap_a: got %h want %h", obs_a(), e);
        end
    endtask

    task automatic test_wrap();
        logic [37:0] e;
        logic [31:0] pcs [5];
        pcs = '{32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8, 32'hC};
        reset = 1'b1;
        entry = 32'hFFFF_FFFC;
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            e = exp_v(1, pcs[i], 2'd0, 0, 0, 0);
            nvec++;
            if (obs_b() !== e) begin
                nerr++;
                $display("FAIL wrap_b%0d: got %h want %h", i, obs_b(), e);
            end
        end
        step();
        e = exp_v(0, 32'hC, 2'd0, 0, 0, 1);
        nvec++;
        if (obs_b() !== e) begin
            nerr++;
            $display("FAIL halt_b: got %h want %h", obs_b(), e);
        end
    endtask

    task automatic test_async_reset();
        logic [37:0] e;
        req_ready = 1'b0;
        step();
        e = exp_v(1, 32'h10, 2'd0, 0, 0, 0);
        nvec++;
        if (obs_a() !== e) begin
            nerr++;
            $display("FAIL pre_reset: got %h want %h", obs_a(), e);
        end
        #2;
        reset = 1'b1;
        #1;
        e = exp_v(0, 32'h0, 2'd0, 0, 0, 0);
        nvec++;
        if (obs_a() !== e) begin
            nerr++;
            $display("FAIL async_a: got %h want %h", obs_a(), e);
        end
        nvec++;
        if (obs_b() !== e) begin
            nerr++;
            $display("FAIL async_b: got %h want %h", obs_b(), e);
        end
        entry = 32'h5000;
        #2;
        reset = 1'b0;
        step();
        e = exp_v(1, 32'h5000, 2'd0, 0, 0, 0);
        nvec++;
        if (obs_a() !== e) begin
            nerr++;
            $display("FAIL reboot: got %h want %h", obs_a(), e);
        end
        req_ready = 1'b1;
        step();
        e = exp_v(1, 32'h5004, 2'd0, 0, 0, 0);
        nvec++;
        if (obs_a() !== e) begin
            nerr++;
            $display("FAIL reboot_seq: got %h want %h", obs_a(), e);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_priority();
        test_epoch_wrap();
        test_halt();
        test_wrap();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
